change_dispenser: RTL and testbench

- Drives the coin hopper that returns change after a ticket purchase. It is the output-side counterpart of the 5/10/20-taka coin acceptor inputs.
- Accepts a change amount from the ticket controller and dispenses it greedily as 20/10/5 coins, one coin per request/acknowledge handshake with the hopper.
- Reports the remaining amount and the number of coins issued to the seven-segment display path.
- Detects hopper jams with an acknowledge timeout.

---
 rtl/change_dispenser_if.sv | 27 ++
 rtl/change_dispenser.sv | 165 ++++++++++++++++
 tb/tb_change_dispenser.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Coin hopper / ticket controller signal bundle for the change dispenser.
// The slave modport is the dispenser itself; the master side is the ticket
// controller plus the hopper, which drive requests and acknowledges.
interface change_dispenser_if;
    logic       start;
    logic [7:0] amount;
    logic       abort;
    logic       coin_ack;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       jam;
    logic [7:0] remaining;
    logic [3:0] coins_out;

    modport slave (
        input  start, amount, abort, coin_ack,
        output coin_req, coin_sel, busy, done, err, jam, remaining, coins_out
    );

    modport master (
        output start, amount, abort, coin_ack,
        input  coin_req, coin_sel, busy, done, err, jam, remaining, coins_out
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a change amount greedily as 20/10/5 taka coins,
// one coin per req/ack handshake with the hopper, with jam detection.
// Every output is a register; status flags are derived from the next state.
module change_dispenser #(
    parameter int MAX_AMOUNT  = 250,
    parameter int ACK_TIMEOUT = 50000000,
    parameter int GAP_CYCLES  = 1000
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SELECT,
        REQ,
        RELEASE,
        GAP,
        JAM
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [3:0]    coins_q, coins_d;
    logic [1:0]    coinSel_q, coinSel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          coinReq_q, busy_q, jam_q;
    logic [7:0]    coinValue;

    // Value in taka of the coin currently being requested from the hopper.
    always_comb begin
        case (coinSel_q)
            2'd2:    coinValue = 8'd20;
            2'd1:    coinValue = 8'd10;
            default: coinValue = 8'd5;
        endcase
    end

    // Next-state logic; abort outside IDLE overrides everything, including a coincident ack.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coins_d     = coins_q;
        coinSel_d   = coinSel_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if ((state_q != IDLE) && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        remaining_d = bus.amount;
                        coins_d     = 4'd0;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    if ((int'(remaining_q) > MAX_AMOUNT) || ((remaining_q % 8'd5) != 8'd0)) begin
                        err_d       = 1'b1;
                        remaining_d = 8'd0;
                        state_d     = IDLE;
                    end else begin
                        state_d = SELECT;
                    end
                end
                SELECT: begin
                    if (remaining_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (remaining_q >= 8'd20) begin
                            coinSel_d = 2'd2;
                        end else if (remaining_q >= 8'd10) begin
                            coinSel_d = 2'd1;
                        end else begin
                            coinSel_d = 2'd0;
                        end
                        timer_d = '0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (bus.coin_ack) begin
                        remaining_d = remaining_q - coinValue;
                        coins_d     = (coins_q == 4'd15) ? 4'd15 : coins_q + 4'd1;
                        state_d     = RELEASE;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d = JAM;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!bus.coin_ack) begin
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = SELECT;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                JAM: begin
                    state_d = JAM;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset drops coin_req immediately without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= 8'd0;
            coins_q     <= 4'd0;
            coinSel_q   <= 2'd0;
            timer_q     <= '0;
            gap_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            coinReq_q   <= 1'b0;
            busy_q      <= 1'b0;
            jam_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coins_q     <= coins_d;
            coinSel_q   <= coinSel_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            err_q       <= err_d;
            coinReq_q   <= (state_d == REQ);
            busy_q      <= (state_d != IDLE);
            jam_q       <= (state_d == JAM);
        end
    end

    assign bus.coin_req  = coinReq_q;
    assign bus.coin_sel  = coinSel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.jam       = jam_q;
    assign bus.remaining = remaining_q;
    assign bus.coins_out = coins_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a hopper model answers coin
// requests while a greedy reference model predicts coin order and totals.
module tb_change_dispenser;
    logic clk;
    logic reset;
    int   compareCount;
    int   mismatchCount;

    change_dispenser_if bus ();

    change_dispenser #(
        .MAX_AMOUNT (250),
        .ACK_TIMEOUT(20),
        .GAP_CYCLES (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start for one cycle; returns at the negedge after the sampling edge.
    task automatic applyStimulus(input logic [7:0] amt);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = amt;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_coin_req"}, int'(bus.coin_req), 0);
        checkOutput({tag, "_coin_sel"}, int'(bus.coin_sel), 0);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_done"}, int'(bus.done), 0);
        checkOutput({tag, "_err"}, int'(bus.err), 0);
        checkOutput({tag, "_jam"}, int'(bus.jam), 0);
        checkOutput({tag, "_remaining"}, int'(bus.remaining), 0);
        checkOutput({tag, "_coins_out"}, int'(bus.coins_out), 0);
    endtask

    // Full transaction with a hopper acking ackDelay cycles into each request.
    task automatic runDispense(input logic [7:0] amt, input int ackDelay, input bit injectStart);
        int    expSel[$];
        int    expRem[$];
        int    left;
        int    cycles;
        int    reqCycles;
        int    ackCnt;
        int    coinIdx;
        int    doneCycle;
        int    doneCount;
        int    errCount;
        bit    legal;
        bit    finished;
        bit    reqSeen;
        bit    injected;
        string tag;
        tag   = $sformatf("amt%0d", amt);
        left  = int'(amt);
        legal = (left <= 250) && ((left % 5) == 0);
        while (legal && left > 0) begin
            if (left >= 20) begin
                expSel.push_back(2);
                left -= 20;
            end else if (left >= 10) begin
                expSel.push_back(1);
                left -= 10;
            end else begin
                expSel.push_back(0);
                left -= 5;
            end
            expRem.push_back(left);
        end
        applyStimulus(amt);
        checkOutput({tag, "_busy_rise"}, int'(bus.busy), 1);
        cycles    = 1;
        reqCycles = 0;
        ackCnt    = 0;
        coinIdx   = 0;
        doneCycle = 0;
        doneCount = 0;
        errCount  = 0;
        finished  = 1'b0;
        reqSeen   = 1'b0;
        injected  = 1'b0;
        while (!finished && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            bus.start = 1'b0;
            if (bus.coin_req) reqSeen = 1'b1;
            if (bus.done) begin
                doneCount++;
                doneCycle = cycles;
                finished  = 1'b1;
            end
            if (bus.err) begin
                errCount++;
                finished = 1'b1;
            end
            if (bus.coin_ack) begin
                ackCnt++;
                if (ackCnt == 1) begin
                    checkOutput($sformatf("%s_rem_coin%0d", tag, coinIdx), int'(bus.remaining),
                                (coinIdx <= expRem.size()) ? expRem[coinIdx-1] : -1);
                    checkOutput($sformatf("%s_cnt_coin%0d", tag, coinIdx), int'(bus.coins_out), coinIdx);
                end
                if (ackCnt >= 2) bus.coin_ack = 1'b0;
            end else if (bus.coin_req) begin
                reqCycles++;
                if (reqCycles == ackDelay) begin
                    checkOutput($sformatf("%s_sel_coin%0d", tag, coinIdx), int'(bus.coin_sel),
                                (coinIdx < expSel.size()) ? expSel[coinIdx] : -1);
                    bus.coin_ack = 1'b1;
                    ackCnt       = 0;
                    reqCycles    = 0;
                    coinIdx++;
                end
            end else if (injectStart && !injected && bus.busy && coinIdx == 1 && ackCnt >= 2) begin
                bus.start  = 1'b1;
                bus.amount = 8'd100;
                injected   = 1'b1;
            end
        end
        bus.start = 1'b0;
        checkOutput({tag, "_finished"}, int'(finished), 1);
        checkOutput({tag, "_busy_end"}, int'(bus.busy), 0);
        checkOutput({tag, "_remaining_end"}, int'(bus.remaining), 0);
        if (legal) begin
            checkOutput({tag, "_done_count"}, doneCount, 1);
            checkOutput({tag, "_err_count"}, errCount, 0);
            checkOutput({tag, "_coins_end"}, int'(bus.coins_out), expSel.size());
            checkOutput({tag, "_coins_requested"}, coinIdx, expSel.size());
            if (amt == 8'd0) begin
                checkOutput({tag, "_done_latency"}, doneCycle, 3);
                checkOutput({tag, "_req_seen"}, int'(reqSeen), 0);
            end
        end else begin
            checkOutput({tag, "_err_count"}, errCount, 1);
            checkOutput({tag, "_done_count"}, doneCount, 0);
            checkOutput({tag, "_req_seen"}, int'(reqSeen), 0);
        end
        @(negedge clk);
        checkOutput({tag, "_done_pulse_end"}, int'(bus.done), 0);
        checkOutput({tag, "_err_pulse_end"}, int'(bus.err), 0);
    endtask

    task automatic waitForReq(input string tag);
        int cycles;
        cycles = 0;
        while (!bus.coin_req && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_req_rise"}, int'(bus.coin_req), 1);
    endtask

    task automatic runJam(input logic [7:0] amt);
        int reqHigh;
        int cycles;
        applyStimulus(amt);
        reqHigh = 0;
        cycles  = 0;
        while (!bus.jam && cycles < 200) begin
            if (bus.coin_req) reqHigh++;
            @(negedge clk);
            cycles++;
        end
        checkOutput("jam_reached", int'(bus.jam), 1);
        checkOutput("jam_req_cycles", reqHigh, 20);
        checkOutput("jam_coin_req", int'(bus.coin_req), 0);
        checkOutput("jam_remaining", int'(bus.remaining), int'(amt));
        checkOutput("jam_busy", int'(bus.busy), 1);
        repeat (3) @(negedge clk);
        checkOutput("jam_held", int'(bus.jam), 1);
        checkOutput("jam_coins_frozen", int'(bus.coins_out), 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("jam_abort_jam", int'(bus.jam), 0);
        checkOutput("jam_abort_busy", int'(bus.busy), 0);
        checkOutput("jam_abort_done", int'(bus.done), 0);
        checkOutput("jam_abort_remaining", int'(bus.remaining), int'(amt));
        @(negedge clk);
        checkOutput("jam_abort_done_after", int'(bus.done), 0);
    endtask

    // Top-level sequence: reset, directed boundaries, random traffic, corner events.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.amount    = 8'd0;
        bus.abort     = 1'b0;
        bus.coin_ack  = 1'b0;
        #23;
        checkIdleZero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        runDispense(8'd35, 2, 1'b0);
        runDispense(8'd0, 2, 1'b0);
        runDispense(8'd250, 1, 1'b0);
        runDispense(8'd37, 2, 1'b0);
        runDispense(8'd255, 2, 1'b0);
        runDispense(8'd5, 3, 1'b0);

        for (int i = 0; i < 6; i++) begin
            runDispense(8'($urandom_range(0, 50) * 5), int'($urandom_range(1, 4)), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            runDispense(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b0);
        end

        runJam(8'd45);

        applyStimulus(8'd30);
        waitForReq("abort_ack");
        bus.coin_ack = 1'b1;
        bus.abort    = 1'b1;
        @(negedge clk);
        bus.coin_ack = 1'b0;
        bus.abort    = 1'b0;
        checkOutput("abort_ack_coins", int'(bus.coins_out), 0);
        checkOutput("abort_ack_remaining", int'(bus.remaining), 30);
        checkOutput("abort_ack_busy", int'(bus.busy), 0);
        checkOutput("abort_ack_coin_req", int'(bus.coin_req), 0);
        checkOutput("abort_ack_done", int'(bus.done), 0);
        @(negedge clk);

        runDispense(8'd30, 2, 1'b1);

        applyStimulus(8'd50);
        waitForReq("async_reset");
        #2;
        reset = 1'b0;
        #1;
        checkIdleZero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        runDispense(8'd65, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
